// File: rtl/global_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpuMemArbTypes (package)
//  Description : Shared types and constants for the global-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpuMemArbTypes;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_DONE  = 2'd2
   } arb_state_t;

   // Read data returned to the core when the memory never acknowledges
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/global_mem_arbiter_picker.sv
`default_nettype none
// ============================================================================
//  Module      : roundRobinPicker
//  Description : Combinational round-robin search. Returns the first
//                requester at or after ptr, wrapping modulo NUM_CORES.
//  Revision    : 1.0 - initial release
// ============================================================================
module roundRobinPicker #(
   parameter int NUM_CORES = 4,
   parameter int IDX_W     = $clog2(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic                 found,
   output logic [IDX_W-1:0]     winner
);

   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_idx;

   // Scan from farthest to nearest so the requester closest to ptr wins last
   always_comb begin
      found  = 1'b0;
      winner = '0;
      w_sum  = '0;
      w_idx  = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(NUM_CORES)) begin
            w_sum = w_sum - (IDX_W+1)'(NUM_CORES);
         end
         w_idx = w_sum[IDX_W-1:0];
         if (req[w_idx]) begin
            found  = 1'b1;
            winner = w_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/global_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : global_mem_arbiter
//  Description : Round-robin arbiter sharing one global-memory port among
//                NUM_CORES cores, one outstanding transaction at a time,
//                four-phase handshake towards each core.
//  Options     : GMEM_ARB_TIMEOUT_EN - ISSUE watchdog (TIMEOUT_CYCLES).
//  Revision    : 1.0 - initial release
// ============================================================================
module global_mem_arbiter
   import gpuMemArbTypes::*;
#(
   parameter int NUM_CORES      = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_CORES-1:0]          coreRead,
   input  logic [NUM_CORES-1:0]          coreWrite,
   input  logic [NUM_CORES*ADDR_W-1:0]   coreAddr,
   input  logic [NUM_CORES*DATA_W-1:0]   coreWData,
   output logic [NUM_CORES-1:0]          coreFinishedRead,
   output logic [NUM_CORES-1:0]          coreFinishedWrite,
   output logic [DATA_W-1:0]             coreRData,
   output logic                          memReq,
   output logic                          memWe,
   output logic [ADDR_W-1:0]             memAddr,
   output logic [DATA_W-1:0]             memWData,
   input  logic                          memAck,
   input  logic [DATA_W-1:0]             memRData,
   output logic                          grantValid,
   output logic [$clog2(NUM_CORES)-1:0]  grantIdx,
   output logic                          timeoutErr
);

   localparam int IDX_W = $clog2(NUM_CORES);

   arb_state_t           r_state;
   arb_state_t           w_nextState;
   logic [NUM_CORES-1:0] w_req;
   logic                 w_found;
   logic [IDX_W-1:0]     w_winner;
   logic [IDX_W-1:0]     r_ptr;
   logic [IDX_W-1:0]     r_grantIdx;
   logic [IDX_W-1:0]     w_nextPtr;
   logic                 w_grantReq;
   logic                 w_timeout;
   logic                 r_memReq;
   logic                 r_memWe;
   logic                 r_grantValid;
   logic [ADDR_W-1:0]    r_memAddr;
   logic [DATA_W-1:0]    r_memWData;
   logic [DATA_W-1:0]    r_coreRData;
   logic [NUM_CORES-1:0] w_grantOneHot;

   assign w_req         = coreRead | coreWrite;
   assign w_grantReq    = w_req[r_grantIdx];
   assign w_nextPtr     = (r_grantIdx == IDX_W'(NUM_CORES - 1)) ? '0 : r_grantIdx + IDX_W'(1);
   assign w_grantOneHot = NUM_CORES'(1) << r_grantIdx;

   roundRobinPicker #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_picker (
      .req    (w_req),
      .ptr    (r_ptr),
      .found  (w_found),
      .winner (w_winner)
   );

`ifdef GMEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_toCnt;
   logic             r_timeoutErr;

   assign w_timeout = (r_state == ARB_ISSUE) && !memAck &&
                      (r_toCnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Watchdog restarts on every grant and counts only while waiting in ISSUE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_toCnt      <= '0;
         r_timeoutErr <= 1'b0;
      end else begin
         if (r_state == ARB_IDLE && w_found) begin
            r_toCnt <= '0;
         end else if (r_state == ARB_ISSUE) begin
            r_toCnt <= r_toCnt + CNT_W'(1);
         end
         if (w_timeout) begin
            r_timeoutErr <= 1'b1;
         end
      end
   end

   assign timeoutErr = r_timeoutErr;
`else
   logic w_unusedTimeout;
   assign w_unusedTimeout = ^(32'(TIMEOUT_CYCLES));
   assign w_timeout       = 1'b0;
   assign timeoutErr      = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic; an ack with the request withdrawn aborts straight to IDLE
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_found) w_nextState = ARB_ISSUE;
         end
         ARB_ISSUE: begin
            if (memAck) begin
               w_nextState = w_grantReq ? ARB_DONE : ARB_IDLE;
            end else if (w_timeout) begin
               w_nextState = ARB_DONE;
            end
         end
         ARB_DONE: begin
            if (!w_grantReq) w_nextState = ARB_IDLE;
         end
         default: w_nextState = ARB_IDLE;
      endcase
   end

   // Grant datapath: latch winner on issue, capture read data, rotate pointer on release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr        <= '0;
         r_grantIdx   <= '0;
         r_memReq     <= 1'b0;
         r_memWe      <= 1'b0;
         r_grantValid <= 1'b0;
         r_memAddr    <= '0;
         r_memWData   <= '0;
         r_coreRData  <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_found) begin
                  r_grantIdx   <= w_winner;
                  r_memWe      <= coreWrite[w_winner];
                  r_memAddr    <= coreAddr[w_winner*ADDR_W +: ADDR_W];
                  r_memWData   <= coreWData[w_winner*DATA_W +: DATA_W];
                  r_memReq     <= 1'b1;
                  r_grantValid <= 1'b1;
               end
            end
            ARB_ISSUE: begin
               if (memAck) begin
                  r_memReq <= 1'b0;
                  if (w_grantReq) begin
                     if (!r_memWe) r_coreRData <= memRData;
                  end else begin
                     r_grantValid <= 1'b0;
                     r_ptr        <= w_nextPtr;
                  end
               end else if (w_timeout) begin
                  r_memReq    <= 1'b0;
                  r_coreRData <= DATA_W'(TIMEOUT_DATA);
               end
            end
            ARB_DONE: begin
               if (!w_grantReq) begin
                  r_grantValid <= 1'b0;
                  r_ptr        <= w_nextPtr;
               end
            end
            default: ;
         endcase
      end
   end

   // Completion flags are decoded from the DONE state and the latched direction
   always_comb begin
      coreFinishedRead  = '0;
      coreFinishedWrite = '0;
      if (r_state == ARB_DONE) begin
         if (r_memWe) coreFinishedWrite = w_grantOneHot;
         else         coreFinishedRead  = w_grantOneHot;
      end
   end

   assign memReq     = r_memReq;
   assign memWe      = r_memWe;
   assign memAddr    = r_memAddr;
   assign memWData   = r_memWData;
   assign coreRData  = r_coreRData;
   assign grantValid = r_grantValid;
   assign grantIdx   = r_grantIdx;

endmodule
`default_nettype wire

// File: tb/tb_global_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_global_mem_arbiter
//  Description : Self-checking bench for global_mem_arbiter with a
//                request-set / memory reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_global_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    coreRead, coreWrite;
   logic [N*AW-1:0] coreAddr;
   logic [N*DW-1:0] coreWData;
   logic [N-1:0]    coreFinishedRead, coreFinishedWrite;
   logic [DW-1:0]   coreRData;
   logic            memReq, memWe;
   logic [AW-1:0]   memAddr;
   logic [DW-1:0]   memWData;
   logic            memAck;
   logic [DW-1:0]   memRData;
   logic            grantValid;
   logic [1:0]      grantIdx;
   logic            timeoutErr;

   global_mem_arbiter #(
      .NUM_CORES (N), .ADDR_W (AW), .DATA_W (DW), .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk), .reset (reset),
      .coreRead (coreRead), .coreWrite (coreWrite),
      .coreAddr (coreAddr), .coreWData (coreWData),
      .coreFinishedRead (coreFinishedRead), .coreFinishedWrite (coreFinishedWrite),
      .coreRData (coreRData),
      .memReq (memReq), .memWe (memWe), .memAddr (memAddr), .memWData (memWData),
      .memAck (memAck), .memRData (memRData),
      .grantValid (grantValid), .grantIdx (grantIdx), .timeoutErr (timeoutErr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the set of cores holding a request and what they ask for
   bit            pend [N];
   bit            wr   [N];
   bit            both [N];
   logic [AW-1:0] ad   [N];
   logic [DW-1:0] wd   [N];
   int            ptrM;
   logic [DW-1:0] memM [logic [AW-1:0]];
   logic [DW-1:0] lastRd;
   bit            toExp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         coreRead[i]  = pend[i] & (~wr[i] | both[i]);
         coreWrite[i] = pend[i] & wr[i];
         coreAddr[i*AW +: AW]  = ad[i];
         coreWData[i*DW +: DW] = wd[i];
      end
   endtask

   task automatic setReq(input int c, input bit isW, input bit isBoth,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend[c] = 1'b1;
      wr[c]   = isW | isBoth;
      both[c] = isBoth;
      ad[c]   = a;
      wd[c]   = d;
      drive();
   endtask

   task automatic randReq(input int c);
      int op;
      op = $urandom_range(0, 3);
      setReq(c, op[0], op == 3, AW'($urandom_range(0, 3) * 4), $urandom);
   endtask

   // First pending core at or after the rotation pointer
   function automatic int pickM();
      for (int k = 0; k < N; k++) begin
         if (pend[(ptrM + k) % N]) return (ptrM + k) % N;
      end
      return -1;
   endfunction

   // One complete grant, starting at a negedge with the DUT in IDLE
   task automatic grant(input int ackDelay, input bit abort, output int got);
      int            w;
      logic [DW-1:0] rd;
      logic [N-1:0]  exp1;
      logic [2*N-1:0] expFin;
      w = pickM();
      @(negedge clk);
      got = int'(grantIdx);
      chk("memReq_on", memReq, 1);
      chk("grantValid_on", grantValid, 1);
      chk("grantIdx", grantIdx, w);
      chk("memWe", memWe, wr[w]);
      chk("memAddr", memAddr, ad[w]);
      chk("memWData", memWData, wd[w]);
      for (int d = 0; d < ackDelay; d++) begin
         @(negedge clk);
         chk("memReq_hold", memReq, 1);
         chk("memAddr_hold", memAddr, ad[w]);
         chk("fin_early", {coreFinishedRead, coreFinishedWrite}, 0);
      end
      if (wr[w]) rd = $urandom;
      else if (memM.exists(ad[w])) rd = memM[ad[w]];
      else begin
         rd = $urandom;
         memM[ad[w]] = rd;
      end
      if (abort) begin
         pend[w] = 1'b0;
         both[w] = 1'b0;
         drive();
      end
      memAck   = 1'b1;
      memRData = rd;
      @(negedge clk);
      memAck   = 1'b0;
      memRData = $urandom;
      chk("memReq_off", memReq, 0);
      ptrM = (w + 1) % N;
      if (abort) begin
         chk("abort_fin", {coreFinishedRead, coreFinishedWrite}, 0);
         chk("abort_gv", grantValid, 0);
         chk("abort_rdata", coreRData, lastRd);
         return;
      end
      exp1 = N'(1) << w;
      if (wr[w]) memM[ad[w]] = wd[w];
      else lastRd = rd;
      expFin = wr[w] ? {{N{1'b0}}, exp1} : {exp1, {N{1'b0}}};
      chk("fin", {coreFinishedRead, coreFinishedWrite}, expFin);
      chk("rdata", coreRData, lastRd);
      chk("gv_done", grantValid, 1);
      // Stray ack while finished is held must be ignored
      memAck   = 1'b1;
      memRData = ~rd;
      @(negedge clk);
      memAck = 1'b0;
      chk("fin_hold", {coreFinishedRead, coreFinishedWrite}, expFin);
      chk("rdata_hold", coreRData, lastRd);
      pend[w] = 1'b0;
      both[w] = 1'b0;
      drive();
      @(negedge clk);
      chk("fin_clear", {coreFinishedRead, coreFinishedWrite}, 0);
      chk("gv_clear", grantValid, 0);
      chk("timeoutErr", timeoutErr, toExp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      int anyPend;
      reset    = 1'b0;
      memAck   = 1'b0;
      memRData = '0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 0; wr[i] = 0; both[i] = 0; ad[i] = '0; wd[i] = '0;
      end
      drive();
      ptrM   = 0;
      lastRd = '0;
      toExp  = 0;

      // Reset state
      #12;
      chk("rst_memReq", memReq, 0);
      chk("rst_gv", grantValid, 0);
      chk("rst_fin", {coreFinishedRead, coreFinishedWrite}, 0);
      chk("rst_rdata", coreRData, 0);
      chk("rst_timeoutErr", timeoutErr, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Single read from core 2, ack on the third ISSUE cycle
      memM[32'h100] = 32'hABCDEF12;
      setReq(2, 0, 0, 32'h100, 32'h0);
      grant(2, 0, got);
      chk("t1_rdata", coreRData, 32'hABCDEF12);

      // Write from core 1
      setReq(1, 1, 0, 32'h40, 32'h12345678);
      grant(0, 0, got);

      // Read+write together on core 3 behaves as a write
      setReq(3, 0, 1, 32'h8, 32'hCAFE0003);
      grant(1, 0, got);

      // Abort on core 0, then pointer must favour core 1 over core 0
      setReq(0, 0, 0, 32'h4, 32'h0);
      grant(1, 1, got);
      setReq(0, 0, 0, 32'h4, 32'h0);
      setReq(1, 0, 0, 32'hC, 32'h0);
      grant(0, 0, got);
      chk("abort_ptr", got, 1);
      grant(0, 0, got);
      chk("abort_next", got, 0);

      // memAck while idle changes nothing
      memAck = 1'b1;
      @(negedge clk);
      memAck = 1'b0;
      chk("idle_ack_req", memReq, 0);
      chk("idle_ack_gv", grantValid, 0);
      chk("idle_ack_fin", {coreFinishedRead, coreFinishedWrite}, 0);

      // Reset mid-ISSUE clears outputs without a clock edge
      setReq(3, 0, 0, 32'h8, 32'h0);
      @(negedge clk);
      chk("pre_rst_req", memReq, 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_memReq", memReq, 0);
      chk("mid_rst_gv", grantValid, 0);
      chk("mid_rst_idx", grantIdx, 0);
      chk("mid_rst_fin", {coreFinishedRead, coreFinishedWrite}, 0);
      for (int i = 0; i < N; i++) begin pend[i] = 0; both[i] = 0; end
      drive();
      ptrM   = 0;
      lastRd = '0;
      @(negedge clk);
      reset = 1'b1;

      // Round robin with all four cores requesting continuously
      for (int i = 0; i < N; i++) randReq(i);
      for (int k = 0; k < 5; k++) begin
         grant(k % 3, 0, got);
         chk("rr_order", got, k % N);
         randReq(got);
      end

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) randReq(i);
         end
         if (pickM() < 0) randReq($urandom_range(0, N - 1));
         grant($urandom_range(0, 3), $urandom_range(0, 7) == 0, got);
      end
      anyPend = 1;
      while (anyPend != 0) begin
         anyPend = 0;
         for (int i = 0; i < N; i++) if (pend[i]) anyPend = 1;
         if (anyPend != 0) grant(0, 0, got);
      end

`ifdef GMEM_ARB_TIMEOUT_EN
      begin
         int cyc;
         logic [2*N-1:0] expFin;
         setReq(1, 0, 0, 32'h20, 32'h0);
         @(negedge clk);
         cyc = 0;
         while (memReq === 1'b1 && cyc < 20) begin
            cyc++;
            @(negedge clk);
         end
         chk("to_cycles", cyc, TO);
         expFin = {4'b0010, 4'b0000};
         chk("to_fin", {coreFinishedRead, coreFinishedWrite}, expFin);
         chk("to_rdata", coreRData, 32'hDEADBEEF);
         chk("to_err", timeoutErr, 1);
         lastRd = 32'hDEADBEEF;
         toExp  = 1;
         pend[1] = 0;
         drive();
         ptrM = 2;
         @(negedge clk);
         chk("to_fin_clear", {coreFinishedRead, coreFinishedWrite}, 0);
         setReq(0, 1, 0, 32'h24, 32'h5A5A5A5A);
         grant(1, 0, got);
         chk("to_err_sticky", timeoutErr, 1);
         #2 reset = 1'b0;
         #1;
         chk("to_err_rst", timeoutErr, 0);
         toExp = 0;
         @(negedge clk);
         reset = 1'b1;
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
